// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: launch FSM state encodings and default sizing for the uart transmit buffer
package uart_tx_fifo_pkg;
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_BUSY_TO = 4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered FIFO with occupancy count; write is rejected when full even if a pop coincides
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd,
  input  logic              flush,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic we, re;
  assign full    = count == (ADDR_W+1)'(DEPTH);
  assign empty   = count == '0;
  assign we      = wr && !full && !flush;
  assign re      = rd && !empty && !flush;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk) if (we) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(we);
      rd_ptr <= rd_ptr + ADDR_W'(re);
      count  <= count + (ADDR_W+1)'(we) - (ADDR_W+1)'(re);
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: CPU-side transmit FIFO drained by a launch FSM that pulses the uart core and tracks its busy flag
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BUSY_TO = DEF_BUSY_TO
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            flush,
  input  logic            ovf_clr,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  output logic            uart_transmit,
  output logic [7:0]      uart_tx_byte,
  input  logic            uart_is_transmitting
);
  localparam int TW = $clog2(BUSY_TO + 1);
  state_t state;
  logic [TW-1:0] timer;
  logic [7:0] rd_data;
  logic pop;
  // a flushed byte must never be launched, so flush also blocks the pop
  assign pop = state == S_IDLE && !empty && !uart_is_transmitting && !flush;
  sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(8)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr(wr_en), .wr_data(wr_data), .rd(pop), .flush(flush),
    .rd_data(rd_data), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else overflow <= (wr_en && full) ? 1'b1 : (flush || ovf_clr) ? 1'b0 : overflow;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          uart_tx_byte  <= rd_data;
          uart_transmit <= 1'b1;
          state         <= S_LAUNCH;
        end
        S_LAUNCH: begin
          uart_transmit <= 1'b0;
          timer         <= TW'(BUSY_TO - 1);
          state         <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: if (uart_is_transmitting) state <= S_WAIT_DONE;
          else if (timer == '0) begin
            uart_transmit <= 1'b1;
            state         <= S_LAUNCH;
          end else timer <= timer - 1'b1;
        S_WAIT_DONE: if (!uart_is_transmitting) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench with a simple uart core model driving uart_is_transmitting
module tb_uart_tx_fifo;
  localparam int FRAME   = 6;
  localparam int BUSY_TO = 4;
  logic clk = 0, rst_n = 0, wr_en = 0, flush = 0, ovf_clr = 0, uart_is_transmitting = 0;
  logic [7:0] wr_data = 0;
  logic full, empty, overflow, uart_transmit;
  logic [4:0] count;
  logic [7:0] uart_tx_byte;
  logic [7:0] exp_q[$];
  logic hold = 0, ignore = 0;
  int vec = 0, err = 0, launches = 0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush), .ovf_clr(ovf_clr),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .uart_transmit(uart_transmit),
    .uart_tx_byte(uart_tx_byte), .uart_is_transmitting(uart_is_transmitting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit acc);
    wr_en = 1; wr_data = b;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic wr_when_room(input logic [7:0] b);
    for (int k = 0; k < 200 && full; k++) @(negedge clk);
    chk("room_timeout", full, 0);
    wr(b, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && (exp_q.size() > 0 || uart_is_transmitting || !empty); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
  endtask

  // uart core model and output monitor
  initial begin
    int frame_left = 0, cyc = 0, ign_cyc = -1;
    logic prev_tx = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        frame_left = 0;
        prev_tx = 0;
      end else begin
        if (uart_transmit) begin
          launches++;
          chk("pulse_width", prev_tx, 0);
          if (exp_q.size() == 0) begin
            vec++; err++;
            $display("FAIL unexpected_launch: got byte %0h expected no launch", uart_tx_byte);
          end else begin
            chk("tx_byte", uart_tx_byte, exp_q[0]);
            if (ignore) begin
              ignore = 0;
              ign_cyc = cyc;
            end else begin
              if (ign_cyc >= 0) begin
                chk("relaunch_gap", cyc - ign_cyc, BUSY_TO + 1);
                ign_cyc = -1;
              end
              void'(exp_q.pop_front());
              frame_left = FRAME;
            end
          end
        end else if (frame_left > 0) frame_left--;
        prev_tx = uart_transmit;
      end
      #1 uart_is_transmitting = hold || frame_left > 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int l0;
    repeat (2) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_transmit", uart_transmit, 0);
    chk("rst_tx_byte", uart_tx_byte, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    // 1: single byte latency
    wr(8'h41, 1);
    chk("t1_count1", count, 1);
    chk("t1_no_tx_yet", uart_transmit, 0);
    @(negedge clk);
    chk("t1_tx", uart_transmit, 1);
    chk("t1_byte", uart_tx_byte, 8'h41);
    chk("t1_count0", count, 0);
    wait_idle();
    // 2: burst to full while uart busy, overflow set beats clear
    hold = 1;
    @(negedge clk);
    for (int i = 0; i < 15; i++) wr(8'(i), 1);
    chk("t2_not_full15", full, 0);
    wr(8'h0F, 1);
    chk("t2_full", full, 1);
    chk("t2_count16", count, 16);
    ovf_clr = 1;
    wr(8'hFF, 0);
    ovf_clr = 0;
    chk("t2_ovf_set_wins", overflow, 1);
    chk("t2_count_kept", count, 16);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("t2_ovf_clr", overflow, 0);
    hold = 0;
    wait_idle();
    // 3: first launch ignored, relaunch with same byte and no pop
    ignore = 1;
    wr(8'h55, 1);
    wr(8'h66, 1);
    repeat (8) @(negedge clk);
    chk("t3_count_kept", count, 1);
    wait_idle();
    // 4: pop and write together at count 5, then 40 bytes across pointer wrap
    hold = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i), 1);
    chk("t4_count5", count, 5);
    hold = 0;
    wr(8'hA5, 1);
    chk("t4_count_same", count, 5);
    chk("t4_launch", uart_transmit, 1);
    for (int i = 6; i < 40; i++) wr_when_room(8'hA0 + 8'(i));
    wait_idle();
    // 5: flush mid-frame with 3 queued and a concurrent write
    wr(8'hD0, 1);
    wr(8'hD1, 0);
    wr(8'hD2, 0);
    wr(8'hD3, 0);
    chk("t5_count3", count, 3);
    flush = 1; wr_en = 1; wr_data = 8'hEE;
    @(negedge clk);
    flush = 0; wr_en = 0;
    chk("t5_empty", empty, 1);
    chk("t5_count0", count, 0);
    l0 = launches;
    wait_idle();
    repeat (20) @(negedge clk);
    chk("t5_no_launch", launches, l0);
    // 6: async reset during WAIT_DONE
    wr(8'h77, 1);
    wr(8'h78, 1);
    repeat (3) @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_full", full, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_transmit", uart_transmit, 0);
    chk("t6_tx_byte", uart_tx_byte, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    l0 = launches;
    repeat (20) @(negedge clk);
    chk("t6_no_launch", launches, l0);
    chk("t6_still_empty", empty, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
